reg_writeback_ctrl: RTL and testbench

// - Write-side front end for the 8x16 LC-3 register file: queues completed results

---
 rtl/lc3_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 76 +++++++
 rtl/reg_writeback_ctrl.sv | 99 +++++++++
 tb/tb_reg_writeback_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Package: lc3_pkg
// Shared types and constants for the LC-3 register write-back path.
//  - wb_entry_t : one queued register write {dr, data, set_cc}
//  - NZP_*      : condition-code encodings, {N,Z,P}
//  - nzp_of()   : condition code produced by a written value
package lc3_pkg;

  localparam int WB_WIDTH = 16;
  localparam int DR_W     = 3;

  typedef struct packed {
    logic [DR_W-1:0]     dr;
    logic [WB_WIDTH-1:0] data;
    logic                set_cc;
  } wb_entry_t;

  localparam logic [2:0] NZP_N     = 3'b100;
  localparam logic [2:0] NZP_Z     = 3'b010;
  localparam logic [2:0] NZP_P     = 3'b001;
  localparam logic [2:0] NZP_RESET = NZP_Z;

  // Sign bit wins, then zero test; everything else is positive.
  function automatic logic [2:0] nzp_of(input logic [WB_WIDTH-1:0] v);
    if (v[WB_WIDTH-1])  return NZP_N;
    else if (v == '0)   return NZP_Z;
    else                return NZP_P;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Module: wb_fifo
// DEPTH-entry circular buffer of write-back entries.
// Ports:
//  clk, rst_n  clock, synchronous active-low reset
//  push, din   enqueue din (caller guarantees not full)
//  pop         dequeue head (caller guarantees not empty)
//  flush       discard all entries; overrides push and pop
//  head        entry at the read pointer
//  count       occupied entries
//  slots       raw storage, slot_valid marks the occupied ones
module wb_fifo
  import lc3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  wb_entry_t                    din,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output wb_entry_t [DEPTH-1:0]        slots,
  output logic [DEPTH-1:0]             slot_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      offset;

  // Pointers are exactly PTR_W bits wide, so they wrap mod DEPTH by overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register in
      // this block samples the pre-edge values, independent of statement order.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read while
  // count marks it occupied, so clearing count is enough to discard it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign slots = mem;

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    slot_valid = '0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rd_ptr;
      slot_valid[i] = (CNT_W'(offset) < count);
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Module: reg_writeback_ctrl
// Write-side front end of the 8x16 LC-3 register file. Completed results are
// queued and presented as at most one registered register write per cycle.
// Ports:
//  Clk, Reset            clock, synchronous active-low reset
//  wb_valid/wb_ready     producer handshake; wb_dr, wb_data, wb_set_cc payload
//  Stall                 hold the queue head
//  Flush                 discard every queued, uncommitted write
//  LD_REG/DR_Sel/BUS_Out registered register-file write strobe, index, data
//  NZP                   condition codes {N,Z,P}
//  busy_mask             registers targeted by a queued or in-flight write
//  count                 occupied queue entries
module reg_writeback_ctrl
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int NREG  = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        wb_valid,
  output logic                        wb_ready,
  input  logic [$clog2(NREG)-1:0]     wb_dr,
  input  logic [WIDTH-1:0]            wb_data,
  input  logic                        wb_set_cc,
  input  logic                        Stall,
  input  logic                        Flush,
  output logic                        LD_REG,
  output logic [$clog2(NREG)-1:0]     DR_Sel,
  output logic [WIDTH-1:0]            BUS_Out,
  output logic [2:0]                  NZP,
  output logic [NREG-1:0]             busy_mask,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t             in_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      slot_valid;
  logic                  push;
  logic                  pop;

  // Ready looks only at the registered count: a full queue refuses a push
  // even in a cycle where it also pops.
  assign wb_ready = (count < CNT_W'(DEPTH));
  assign push     = wb_valid & wb_ready;
  assign pop      = (count != '0) & ~Stall & ~Flush;

  always_comb begin
    in_entry        = '0;
    in_entry.dr     = wb_dr;
    in_entry.data   = wb_data;
    in_entry.set_cc = wb_set_cc;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clk),
    .rst_n      (Reset),
    .push       (push),
    .pop        (pop),
    .flush      (Flush),
    .din        (in_entry),
    .head       (head),
    .count      (count),
    .slots      (slots),
    .slot_valid (slot_valid)
  );

  // Output register stage. Flush blocks pop, so it also drops LD_REG; a write
  // already showing LD_REG during the flush cycle commits on that same edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      LD_REG  <= 1'b0;
      DR_Sel  <= '0;
      BUS_Out <= '0;
      NZP     <= NZP_RESET;
    end else if (pop) begin
      LD_REG  <= 1'b1;
      DR_Sel  <= head.dr;
      BUS_Out <= head.data;
      if (head.set_cc) NZP <= nzp_of(head.data);
    end else begin
      LD_REG  <= 1'b0;
    end
  end

  // Interlock mask: queued entries plus the write currently on the bus.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) busy_mask[slots[i].dr] = 1'b1;
    end
    if (LD_REG) busy_mask[DR_Sel] = 1'b1;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Testbench: tb_reg_writeback_ctrl
// Drives reg_writeback_ctrl and compares every cycle against a queue-based
// behavioural model of the write-back queue, plus fixed expectations for the
// directed scenarios.
module tb_reg_writeback_ctrl;
  import lc3_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        wb_set_cc;
  logic        Stall;
  logic        Flush;
  logic        LD_REG;
  logic [2:0]  DR_Sel;
  logic [15:0] BUS_Out;
  logic [2:0]  NZP;
  logic [7:0]  busy_mask;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  reg_writeback_ctrl #(.WIDTH(16), .DEPTH(DEPTH), .NREG(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_dr     (wb_dr),
    .wb_data   (wb_data),
    .wb_set_cc (wb_set_cc),
    .Stall     (Stall),
    .Flush     (Flush),
    .LD_REG    (LD_REG),
    .DR_Sel    (DR_Sel),
    .BUS_Out   (BUS_Out),
    .NZP       (NZP),
    .busy_mask (busy_mask),
    .count     (count)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  wb_entry_t   m_q[$];
  logic        m_ld   = 1'b0;
  logic [2:0]  m_dr   = '0;
  logic [15:0] m_data = '0;
  logic [2:0]  m_nzp  = 3'b010;

  logic [34:0] obs;
  assign obs = {LD_REG, DR_Sel, BUS_Out, NZP, count, busy_mask, wb_ready};

  function automatic logic [34:0] exp_vec();
    logic [7:0] bm;
    bm = '0;
    foreach (m_q[i]) bm[m_q[i].dr] = 1'b1;
    if (m_ld) bm[m_dr] = 1'b1;
    return {m_ld, m_dr, m_data, m_nzp, 3'(m_q.size()), bm, (m_q.size() < DEPTH)};
  endfunction

  // Drive one cycle of inputs, advance one clock edge, update the model, and
  // leave time 1 unit after the edge for sampling.
  task automatic tick(input logic v, input logic [2:0] dr, input logic [15:0] d,
                      input logic cc, input logic st, input logic fl, input logic rn);
    wb_entry_t e;
    logic acc, pop;
    wb_valid = v; wb_dr = dr; wb_data = d; wb_set_cc = cc;
    Stall = st; Flush = fl; Reset = rn;
    acc = v && (m_q.size() < DEPTH);
    pop = (m_q.size() != 0) && !st && !fl;
    @(posedge Clk);
    if (!rn) begin
      m_q.delete();
      m_ld = 1'b0; m_dr = '0; m_data = '0; m_nzp = 3'b010;
    end else begin
      if (pop) begin
        e = m_q.pop_front();
        m_ld = 1'b1; m_dr = e.dr; m_data = e.data;
        if (e.set_cc) m_nzp = e.data[15] ? 3'b100 : (e.data == 16'h0 ? 3'b010 : 3'b001);
      end else begin
        m_ld = 1'b0;
      end
      if (fl) m_q.delete();
      else if (acc) begin
        e.dr = dr; e.data = d; e.set_cc = cc;
        m_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic st);
    tick(1'b0, 3'd0, 16'h0, 1'b0, st, 1'b0, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    // get traffic going, then reset mid-stream for two cycles
    tick(1'b1, 3'd6, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 3'd2, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 3'd1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'd1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({LD_REG, NZP, busy_mask, count, wb_ready} !== {1'b0, 3'b010, 8'h00, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got ld=%b nzp=%b busy=%h cnt=%0d rdy=%b want ld=0 nzp=010 busy=00 cnt=0 rdy=1",
               LD_REG, NZP, busy_mask, count, wb_ready);
    end
    checks++;
    if ({DR_Sel, BUS_Out} !== 19'h0) begin
      errors++;
      $display("FAIL reset_bus: got dr=%0d bus=%h want 0/0000", DR_Sel, BUS_Out);
    end
    idle(1'b0);
  endtask

  task automatic test_single();
    tick(1'b1, 3'd3, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({LD_REG, count, busy_mask} !== {1'b0, 3'd1, 8'h08}) begin
      errors++;
      $display("FAIL single_accept: got ld=%b cnt=%0d busy=%h want ld=0 cnt=1 busy=08", LD_REG, count, busy_mask);
    end
    idle(1'b0);
    checks++;
    if ({LD_REG, DR_Sel, BUS_Out, NZP, busy_mask} !== {1'b1, 3'd3, 16'h8001, 3'b100, 8'h08}) begin
      errors++;
      $display("FAIL single_write: got ld=%b dr=%0d bus=%h nzp=%b busy=%h want 1/3/8001/100/08",
               LD_REG, DR_Sel, BUS_Out, NZP, busy_mask);
    end
    idle(1'b0);
    checks++;
    if ({LD_REG, busy_mask} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL single_done: got ld=%b busy=%h want ld=0 busy=00", LD_REG, busy_mask);
    end
  endtask

  task automatic test_full();
    int n_acc;
    int ld_dr[$];
    int ld_cyc[$];
    int next_dr;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_ready) n_acc++;
      tick(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 1'b1, 1'b0, 1'b1);
    end
    checks++;
    if (n_acc != 4 || wb_ready !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL full_accept: got acc=%0d rdy=%b cnt=%0d want acc=4 rdy=0 cnt=4", n_acc, wb_ready, count);
    end
    next_dr = 4;  // dr=4 is still being offered until taken
    for (int c = 0; c < 20; c++) begin
      if (next_dr == 4 && wb_ready) begin
        tick(1'b1, 3'd4, 16'h1004, 1'b0, 1'b0, 1'b0, 1'b1);
        next_dr = 5;
      end else if (next_dr == 4) begin
        tick(1'b1, 3'd4, 16'h1004, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        idle(1'b0);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain: got %h want %h", obs, exp_vec());
      end
      if (LD_REG === 1'b1) begin
        ld_dr.push_back(int'(DR_Sel));
        ld_cyc.push_back(c);
      end
    end
    checks++;
    if (ld_dr.size() != 5) begin
      errors++;
      $display("FAIL full_ld_count: got %0d want 5", ld_dr.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (ld_dr[k] != k || ld_cyc[k] != ld_cyc[0] + k) begin
          errors++;
          $display("FAIL full_order[%0d]: got dr=%0d cyc=%0d want dr=%0d cyc=%0d",
                   k, ld_dr[k], ld_cyc[k], k, ld_cyc[0] + k);
        end
      end
    end
  endtask

  task automatic test_cc();
    tick(1'b1, 3'd1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    checks++;
    if (NZP !== 3'b001) begin
      errors++;
      $display("FAIL cc_setup: got nzp=%b want 001", NZP);
    end
    tick(1'b1, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 3'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({LD_REG, DR_Sel, NZP} !== {1'b1, 3'd5, 3'b001}) begin
      errors++;
      $display("FAIL cc_no_update: got ld=%b dr=%0d nzp=%b want 1/5/001", LD_REG, DR_Sel, NZP);
    end
    idle(1'b0);
    checks++;
    if ({LD_REG, DR_Sel, NZP} !== {1'b1, 3'd5, 3'b010}) begin
      errors++;
      $display("FAIL cc_zero: got ld=%b dr=%0d nzp=%b want 1/5/010", LD_REG, DR_Sel, NZP);
    end
    idle(1'b0);
  endtask

  task automatic test_wrap();
    tick(1'b1, 3'd6, 16'hA000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 3'd7, 16'hA001, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
      checks++;
      if (count !== 3'd2 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h want %h (count %0d want 2)", i, obs, exp_vec(), count);
      end
    end
    for (int i = 0; i < 3; i++) idle(1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) tick(1'b1, 3'(i + 1), 16'h2000 + 16'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 3'd7, 16'hDEAD, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({count, busy_mask, LD_REG} !== {3'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL flush_clear: got cnt=%0d busy=%h ld=%b want 0/00/0", count, busy_mask, LD_REG);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      checks++;
      if (LD_REG !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_write[%0d]: got ld=%b dr=%0d bus=%h want ld=0", i, LD_REG, DR_Sel, BUS_Out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 59) != 0));
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_cc();
    test_wrap();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
